// File: rtl/font_rom_arbiter.sv
// rtl/font_rom_arbiter.sv - font ROM read arbiter for label and digit paths (option: FONT_ARB_RR_EN)
module font_rom_arbiter #(
    parameter int ADDR_W     = 20,
    parameter int ROM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic              reloj,
    input  logic              resetM,
    input  logic              req_a,
    input  logic [ADDR_W-1:0] addr_a,
    output logic              gnt_a,
    output logic              vld_a,
    output logic [7:0]        data_a,
    input  logic              req_b,
    input  logic [ADDR_W-1:0] addr_b,
    output logic              gnt_b,
    output logic              vld_b,
    output logic [7:0]        data_b,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              busy
);

    // Tag pipeline: valid bit and requester id (1 = B) for each read in flight.
    logic [ROM_LAT:0] tag_v;
    logic [ROM_LAT:0] tag_b;
    logic             win_b;
    logic             grant;

    assign grant = gnt_a | gnt_b;

`ifdef FONT_ARB_RR_EN
    // Pointer names who is preferred on contention; 0 = A.
    logic rr_ptr;
    assign win_b = rr_ptr;

    // After each grant, hand preference to the requester that lost.
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            rr_ptr <= 1'b0;
        end else if (gnt_a) begin
            rr_ptr <= 1'b1;
        end else if (gnt_b) begin
            rr_ptr <= 1'b0;
        end
    end
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    logic [3:0] wait_b;
    assign win_b = (wait_b == STARVE_LIM);

    // Count consecutive denied B cycles; a dropped or granted request starts over.
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            wait_b <= 4'd0;
        end else if (!req_b || gnt_b) begin
            wait_b <= 4'd0;
        end else if (wait_b != STARVE_LIM) begin
            wait_b <= wait_b + 4'd1;
        end
    end
`endif

    // Single-winner arbitration; grants are suppressed while reset is held.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!resetM) begin
            if (req_b && (!req_a || win_b)) begin
                gnt_b = 1'b1;
            end else if (req_a) begin
                gnt_a = 1'b1;
            end
        end
    end

    // Register the winning address onto the ROM port; address holds when idle.
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            rom_en   <= 1'b0;
            rom_addr <= '0;
        end else begin
            rom_en <= grant;
            if (gnt_b) begin
                rom_addr <= addr_b;
            end else if (gnt_a) begin
                rom_addr <= addr_a;
            end
        end
    end

    // Shift tags alongside the ROM latency so the last stage lines up with rom_data.
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            tag_v <= '0;
            tag_b <= '0;
        end else begin
            tag_v <= {tag_v[ROM_LAT-1:0], grant};
            tag_b <= {tag_b[ROM_LAT-1:0], gnt_b};
        end
    end

    // Steer the returned byte to the tagged requester only.
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            vld_a  <= 1'b0;
            vld_b  <= 1'b0;
            data_a <= 8'd0;
            data_b <= 8'd0;
        end else begin
            vld_a <= tag_v[ROM_LAT] && !tag_b[ROM_LAT];
            vld_b <= tag_v[ROM_LAT] && tag_b[ROM_LAT];
            if (tag_v[ROM_LAT] && !tag_b[ROM_LAT]) begin
                data_a <= rom_data;
            end
            if (tag_v[ROM_LAT] && tag_b[ROM_LAT]) begin
                data_b <= rom_data;
            end
        end
    end

    assign busy = |tag_v;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// tb/tb_font_rom_arbiter.sv - directed self-checking bench for font_rom_arbiter
module tb_font_rom_arbiter;

    logic        reloj = 1'b0;
    logic        resetM = 1'b1;
    logic        req_a = 1'b0;
    logic [19:0] addr_a = '0;
    logic        gnt_a;
    logic        vld_a;
    logic [7:0]  data_a;
    logic        req_b = 1'b0;
    logic [19:0] addr_b = '0;
    logic        gnt_b;
    logic        vld_b;
    logic [7:0]  data_b;
    logic        rom_en;
    logic [19:0] rom_addr;
    logic [7:0]  rom_data = 8'd0;
    logic        busy;

    int checks = 0;
    int failures = 0;

    font_rom_arbiter #(.ADDR_W(20), .ROM_LAT(1), .STARVE_MAX(3)) dut (
        .reloj(reloj), .resetM(resetM),
        .req_a(req_a), .addr_a(addr_a), .gnt_a(gnt_a), .vld_a(vld_a), .data_a(data_a),
        .req_b(req_b), .addr_b(addr_b), .gnt_b(gnt_b), .vld_b(vld_b), .data_b(data_b),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
    );

    always #5 reloj = ~reloj;

    function automatic logic [7:0] rom_byte(input logic [19:0] a);
        return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]};
    endfunction

    // ROM model with one cycle of read latency.
    always @(posedge reloj) begin
        if (rom_en) rom_data <= rom_byte(rom_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge reloj);
        #1;
    endtask

    task automatic pulse_reset();
        resetM = 1'b1;
        step();
        resetM = 1'b0;
    endtask

    logic        exp_b [8];
    logic [19:0] tp_addr [4];
    logic        tp_isb [4];

    initial begin
        // Reset state, with requests present to show grants are held off.
        req_a = 1'b1; req_b = 1'b1;
        step(); #1;
        check("rst_gnt_a", gnt_a, 0);
        check("rst_gnt_b", gnt_b, 0);
        check("rst_vld_a", vld_a, 0);
        check("rst_vld_b", vld_b, 0);
        check("rst_rom_en", rom_en, 0);
        check("rst_busy", busy, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_data_a", data_a, 0);
        check("rst_data_b", data_b, 0);
        req_a = 1'b0; req_b = 1'b0;
        step();
        resetM = 1'b0;

        // Single read from A.
        step();
        req_a = 1'b1; addr_a = 20'h0B160; #1;
        check("single_gnt_a", gnt_a, 1);
        check("single_gnt_b", gnt_b, 0);
        step();
        req_a = 1'b0; #1;
        check("single_rom_en", rom_en, 1);
        check("single_rom_addr", rom_addr, 20'h0B160);
        check("single_busy", busy, 1);
        step(); #1;
        check("single_vld_a_c2", vld_a, 0);
        step(); #1;
        check("single_vld_a_c3", vld_a, 1);
        check("single_data_a", data_a, 8'hD1);
        check("single_vld_b_c3", vld_b, 0);
        step(); #1;
        check("single_vld_a_c4", vld_a, 0);
        check("single_busy_end", busy, 0);
        check("single_rom_en_end", rom_en, 0);

        // Contention: both held high.
`ifdef FONT_ARB_RR_EN
        exp_b = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_b = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
        pulse_reset();
        addr_a = 20'h00A41; addr_b = 20'h00B37;
        for (int c = 0; c < 11; c++) begin
            step();
            req_a = (c < 8); req_b = (c < 8); #1;
            if (c < 8) begin
                check($sformatf("cont_gnt_b_%0d", c), gnt_b, exp_b[c]);
                check($sformatf("cont_gnt_a_%0d", c), gnt_a, !exp_b[c]);
            end
            if (c >= 3) begin
                check($sformatf("cont_vld_b_%0d", c), vld_b, exp_b[c-3]);
                check($sformatf("cont_vld_a_%0d", c), vld_a, !exp_b[c-3]);
                if (exp_b[c-3]) check($sformatf("cont_data_b_%0d", c), data_b, 8'h3C);
                else            check($sformatf("cont_data_a_%0d", c), data_a, 8'h4B);
            end
        end

        // Full throughput: alternating single-cycle requests.
        tp_addr = '{20'h12345, 20'h23456, 20'h3489A, 20'h4ABCD};
        tp_isb  = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int c = 0; c < 8; c++) begin
            step();
            req_a = (c < 4) && !tp_isb[c & 3];
            req_b = (c < 4) && tp_isb[c & 3];
            if (c < 4) begin
                addr_a = tp_addr[c];
                addr_b = tp_addr[c];
            end
            #1;
            if (c < 4) begin
                check($sformatf("tp_gnt_a_%0d", c), gnt_a, !tp_isb[c]);
                check($sformatf("tp_gnt_b_%0d", c), gnt_b, tp_isb[c]);
            end
            if (c >= 1 && c <= 4) begin
                check($sformatf("tp_rom_en_%0d", c), rom_en, 1);
                check($sformatf("tp_rom_addr_%0d", c), rom_addr, tp_addr[c-1]);
            end
            if (c == 5) check("tp_rom_en_off", rom_en, 0);
            if (c >= 3 && c <= 6) begin
                check($sformatf("tp_vld_a_%0d", c), vld_a, !tp_isb[c-3]);
                check($sformatf("tp_vld_b_%0d", c), vld_b, tp_isb[c-3]);
                if (tp_isb[c-3]) check($sformatf("tp_data_b_%0d", c), data_b, rom_byte(tp_addr[c-3]));
                else             check($sformatf("tp_data_a_%0d", c), data_a, rom_byte(tp_addr[c-3]));
            end
        end

        // Reset while a B read is in flight.
        step();
        req_b = 1'b1; addr_b = 20'h05A5A; #1;
        check("rmf_gnt_b", gnt_b, 1);
        step();
        req_b = 1'b0; resetM = 1'b1; #1;
        check("rmf_rom_en", rom_en, 0);
        check("rmf_rom_addr", rom_addr, 0);
        check("rmf_busy", busy, 0);
        check("rmf_data_b", data_b, 0);
        check("rmf_data_a", data_a, 0);
        step();
        resetM = 1'b0;
        for (int c = 2; c < 6; c++) begin
            #1;
            check($sformatf("rmf_vld_b_%0d", c), vld_b, 0);
            check($sformatf("rmf_busy_%0d", c), busy, 0);
            step();
        end

`ifndef FONT_ARB_RR_EN
        // Withdrawal: B asks twice, drops, and later must wait the full bound again.
        addr_a = 20'h00111; addr_b = 20'h00222;
        for (int c = 0; c < 8; c++) begin
            step();
            req_a = 1'b1;
            req_b = (c < 2) || (c >= 4);
            #1;
            check($sformatf("wd_gnt_b_%0d", c), gnt_b, (c == 7));
            check($sformatf("wd_gnt_a_%0d", c), gnt_a, (c != 7));
        end
        step();
        req_a = 1'b0; req_b = 1'b0;
        for (int c = 0; c < 4; c++) step();
        #1;
        check("wd_busy_end", busy, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
